keypad_responder: RTL and testbench

Synthesizable 4x4 matrix-keypad emulator: the responder end of the column-scan/row-sense keypad interface. It takes key-press commands (key code plus hold time) and drives `fila` back to the keypad scanner in response to the scanner's `col` drive, exactly as a physical switch matrix would. It replaces the physical keypad for on-board self-test and simulation. With bounce injection enabled, it can also exercise the scanner's debounce path.

---
 rtl/kpd_pkg.sv | 21 ++
 rtl/kpd_lfsr.sv | 26 ++
 rtl/keypad_responder.sv | 153 +++++++++++++++
 tb/tb_keypad_responder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/kpd_pkg.sv
// Keypad responder shared definitions: FSM states, LFSR seed/taps, key-field bit positions.
// Latency/backpressure: n/a (types and constants only).
package kpd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    B_IN  = 2'd1,
    HELD  = 2'd2,
    B_OUT = 2'd3
  } kpd_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps at bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

endpackage

// File: rtl/kpd_lfsr.sv
// 16-bit Fibonacci LFSR used as the contact-chatter source; advances one step per enabled cycle.
// Latency: state registered; backpressure: none (free-running while en is high).
module kpd_lfsr
  import kpd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/keypad_responder.sv
// 4x4 matrix-keypad emulator: closes one key for a commanded hold time; fila registered, 1 cycle behind contact/col.
// One command at a time (cmd_ready only in IDLE, nothing queued); KPD_BOUNCE_EN adds LFSR chatter windows.
module keypad_responder
  import kpd_pkg::*;
#(
  parameter int HOLD_W     = 24,
  parameter int BOUNCE_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [3:0]        col,
  output logic [3:0]        fila,
  output logic              busy,
  output logic              done
);

  kpd_state_e        state_q, state_d;
  logic [1:0]        row_q, row_d, csel_q, csel_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d, hold_in;
  logic [3:0]        fila_q, fila_d;
  logic              done_q, done_d;
  logic              contact;

  if (BOUNCE_CYC < 1) begin : g_cfg_chk
    $error("BOUNCE_CYC must be >= 1");
  end

`ifdef KPD_BOUNCE_EN
  localparam int BCNT_W = $clog2(BOUNCE_CYC + 1);
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [HOLD_W-1:0] hlat_q, hlat_d;
  logic              lfsr_en;
  logic [15:0]       lfsr_state;

  kpd_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (lfsr_en),
    .state (lfsr_state)
  );
`endif

  assign hold_in = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    csel_d  = csel_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    contact = 1'b0;
`ifdef KPD_BOUNCE_EN
    hlat_d  = hlat_q;
    bcnt_d  = bcnt_q;
    lfsr_en = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          row_d  = cmd_key[KEY_ROW_MSB:KEY_ROW_LSB];
          csel_d = cmd_key[KEY_COL_MSB:KEY_COL_LSB];
`ifdef KPD_BOUNCE_EN
          hlat_d  = hold_in;
          bcnt_d  = BCNT_W'(BOUNCE_CYC);
          state_d = B_IN;
`else
          hcnt_d  = hold_in;
          state_d = HELD;
`endif
        end
      end
`ifdef KPD_BOUNCE_EN
      B_IN: begin
        contact = lfsr_state[0];
        lfsr_en = 1'b1;
        if (bcnt_q == BCNT_W'(1)) begin
          hcnt_d  = hlat_q;
          state_d = HELD;
        end else begin
          bcnt_d = bcnt_q - BCNT_W'(1);
        end
      end
      B_OUT: begin
        contact = lfsr_state[0];
        lfsr_en = 1'b1;
        if (bcnt_q == BCNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          bcnt_d = bcnt_q - BCNT_W'(1);
        end
      end
`endif
      HELD: begin
        contact = 1'b1;
        // Exit on 1 rather than 0 so a hold of 2^HOLD_W-1 never needs to wrap.
        if (hcnt_q == HOLD_W'(1)) begin
`ifdef KPD_BOUNCE_EN
          bcnt_d  = BCNT_W'(BOUNCE_CYC);
          state_d = B_OUT;
`else
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          hcnt_d = hcnt_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    fila_d = (contact && col[csel_q]) ? (4'b0001 << row_q) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      csel_q  <= '0;
      hcnt_q  <= '0;
      fila_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      csel_q  <= csel_d;
      hcnt_q  <= hcnt_d;
      fila_q  <= fila_d;
      done_q  <= done_d;
    end
  end

`ifdef KPD_BOUNCE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= '0;
      hlat_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      hlat_q <= hlat_d;
    end
  end
`endif

  assign fila      = fila_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign cmd_ready = (state_q == IDLE);

endmodule

// File: tb/tb_keypad_responder.sv
// Bench for keypad_responder: directed plus random press commands against a cycle-window reference model.
// Bounce windows (KPD_BOUNCE_EN) are modelled as "contact unknown"; only timing and the stable window are checked there.
module tb_keypad_responder;

  localparam int HW = 24;
`ifdef KPD_BOUNCE_EN
  localparam int BNC = 8;
`else
  localparam int BNC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_key;
  logic [HW-1:0] cmd_hold;
  logic [3:0]    col;
  logic [3:0]    fila;
  logic          busy;
  logic          done;

  keypad_responder #(.HOLD_W(HW), .BOUNCE_CYC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_hold  (cmd_hold),
    .col       (col),
    .fila      (fila),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference: one press record; accept in cycle a, key closed in a+BNC+1 .. a+BNC+h.
  bit         act = 1'b0;
  int         m_a, m_h;
  logic [1:0] m_r, m_c;
  int         done_cyc = -1;
  logic [3:0] exp_fila = 4'b0000;
  bit         fila_known = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    return act && (c >= m_a + 1) && (c <= m_a + 2*BNC + m_h);
  endfunction

  task automatic cyc_step(input bit v, input logic [3:0] k, input int h, input logic [3:0] cl);
    bit ready, ct, ck;
    @(negedge clk);
    ready = !m_busy(cyc);
    check("busy", busy, !ready);
    check("cmd_ready", cmd_ready, ready);
    check("done", done, cyc == done_cyc);
    if (fila_known) check("fila", fila, exp_fila);
    cmd_valid = v;
    cmd_key   = k;
    cmd_hold  = h[HW-1:0];
    col       = cl;
    if (m_busy(cyc)) begin
      ck = (cyc >= m_a + BNC + 1) && (cyc <= m_a + BNC + m_h);
      ct = ck;
    end else begin
      ck = 1'b1;
      ct = 1'b0;
    end
    fila_known = ck || !cl[m_c];
    exp_fila   = (ct && cl[m_c]) ? (4'b0001 << m_r) : 4'b0000;
    if (v && ready) begin
      act      = 1'b1;
      m_a      = cyc;
      m_h      = (h == 0) ? 1 : h;
      m_r      = k[3:2];
      m_c      = k[1:0];
      done_cyc = cyc + 2*BNC + m_h + 1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("rst_fila", fila, 4'b0000);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    act        = 1'b0;
    done_cyc   = -1;
    exp_fila   = 4'b0000;
    fila_known = 1'b1;
    repeat (2) begin
      @(negedge clk);
      cyc++;
      check("rst_hold_fila", fila, 4'b0000);
      check("rst_hold_busy", busy, 1'b0);
    end
    rst = 1'b1;
    cyc++;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    cmd_hold  = '0;
    col       = 4'hF;
    #2;
    do_reset();
    repeat (3) cyc_step(1'b0, 4'h0, 0, 4'hF);

    // Basic press: row 1, column 2, hold 5.
    cyc_step(1'b1, 4'b0110, 5, 4'b0100);
    repeat (8 + 2*BNC) cyc_step(1'b0, 4'b0110, 5, 4'b0100);

    // Rotating column scan, then a column that never matches.
    for (int i = 0; i < 14 + 2*BNC; i++)
      cyc_step(i == 0, 4'b0110, 5, 4'b0001 << (i % 4));
    cyc_step(1'b1, 4'b0110, 5, 4'b0001);
    repeat (8 + 2*BNC) cyc_step(1'b0, 4'b0110, 5, 4'b0001);

    // Hold 0 behaves as 1; valid pulses while busy are dropped.
    cyc_step(1'b1, 4'b1011, 0, 4'hF);
    repeat (4 + 2*BNC) cyc_step(1'b0, 4'b1011, 0, 4'hF);
    cyc_step(1'b1, 4'b0001, 6, 4'hF);
    cyc_step(1'b1, 4'b1110, 2, 4'hF);
    cyc_step(1'b0, 4'b1110, 2, 4'hF);
    cyc_step(1'b1, 4'b1111, 3, 4'hF);
    repeat (6 + 2*BNC) cyc_step(1'b0, 4'h0, 0, 4'hF);

    // Valid held high: each new command is taken in the done cycle.
    for (int i = 0; i < 30 + 6*BNC; i++)
      cyc_step(1'b1, 4'(i), (i % 3) + 1, 4'hF);
    repeat (6 + 2*BNC) cyc_step(1'b0, 4'h0, 0, 4'hF);

    // Reset in the 3rd held cycle of a hold-10 press.
    cyc_step(1'b1, 4'b1001, 10, 4'hF);
    repeat (3 + BNC) cyc_step(1'b0, 4'b1001, 10, 4'hF);
    do_reset();
    repeat (15 + 2*BNC) cyc_step(1'b0, 4'h0, 0, 4'hF);

    // Random commands, columns and holds.
    for (int i = 0; i < 800; i++)
      cyc_step($urandom_range(0, 3) == 0, 4'($urandom), int'($urandom_range(0, 9)), 4'($urandom));
    repeat (12 + 2*BNC) cyc_step(1'b0, 4'h0, 0, 4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
